// File: rtl/keypad_hex_scan.sv
// 4x4 hex keypad scanner: column strobing, per-scan key resolution and press/release debounce.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat strobes while a key stays held.
module keypad_hex_scan #(
    parameter int SETTLE_W     = 10,
    parameter int DB_SCANS     = 4,
    parameter int REPEAT_SCANS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       multi
);

    if (DB_SCANS < 1 || DB_SCANS > 15 || REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_param_check
        $error("keypad_hex_scan: DB_SCANS or REPEAT_SCANS out of range");
    end

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    localparam logic [3:0] DB_LAST = 4'(DB_SCANS);

    logic [3:0]          row_sync_p0, row_sync_p1;
    logic [SETTLE_W-1:0] dwell;
    logic [1:0]          col_idx;
    logic                sample_en, eval_en;
    logic [3:0]          hits;
    logic [1:0]          col_hits, hit_row;
    logic [1:0]          acc_cnt;
    logic [3:0]          acc_code;
    logic [2:0]          hit_sum;
    logic [1:0]          tot_cnt;
    logic [3:0]          scan_code;
    logic                res_none, res_single, res_multi;

    state_t     state, state_nxt;
    logic [3:0] cand, cand_nxt;
    logic [3:0] db_cnt, cnt_nxt, db_inc;
    logic [3:0] code_nxt;
    logic       down_nxt;
    logic       accept;
    logic       valid_nxt;

    assign col       = ~(4'b0001 << col_idx);
    assign sample_en = &dwell;
    assign eval_en   = sample_en && (col_idx == 2'd3);
    assign hits      = ~row_sync_p1;

    // Lowest active row wins the code; more than one hit in a column already means MULTI.
    always_comb begin
        col_hits = 2'd0;
        hit_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (hits[r]) begin
                hit_row = 2'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
    end

    assign hit_sum    = {1'b0, acc_cnt} + {1'b0, col_hits};
    assign tot_cnt    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign scan_code  = (acc_cnt == 2'd0) ? {hit_row, col_idx} : acc_code;
    assign res_none   = (tot_cnt == 2'd0);
    assign res_single = (tot_cnt == 2'd1);
    assign res_multi  = (tot_cnt == 2'd2);
    assign db_inc     = db_cnt + 4'd1;

    // Row synchronizer, column scan and per-scan accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            row_sync_p0 <= 4'b1111;
            row_sync_p1 <= 4'b1111;
            dwell       <= '0;
            col_idx     <= 2'd0;
            acc_cnt     <= 2'd0;
            acc_code    <= 4'd0;
            multi       <= 1'b0;
        end else begin
            row_sync_p0 <= row;
            row_sync_p1 <= row_sync_p0;
            dwell       <= dwell + 1'b1;
            if (sample_en) begin
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'd0;
                    multi    <= res_multi;
                end else begin
                    acc_cnt  <= tot_cnt;
                    acc_code <= scan_code;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = db_cnt;
        code_nxt  = key_code;
        down_nxt  = key_down;
        accept    = 1'b0;
        if (eval_en) begin
            case (state)
                IDLE: begin
                    if (res_single) begin
                        if (DB_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = PRESS_CHK;
                            cand_nxt  = scan_code;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (res_single && scan_code == cand) begin
                        if (db_inc == DB_LAST) accept = 1'b1;
                        else                   cnt_nxt = db_inc;
                    end else if (res_single) begin
                        cand_nxt = scan_code;
                        cnt_nxt  = 4'd1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
                HELD: begin
                    if (!(res_multi || (res_single && scan_code == key_code))) begin
                        if (DB_SCANS == 1) begin
                            state_nxt = IDLE;
                            down_nxt  = 1'b0;
                        end else begin
                            state_nxt = RELEASE_CHK;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                RELEASE_CHK: begin
                    if (res_none || (res_single && scan_code != key_code)) begin
                        if (db_inc == DB_LAST) begin
                            state_nxt = IDLE;
                            down_nxt  = 1'b0;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = db_inc;
                        end
                    end else begin
                        state_nxt = HELD;
                        cnt_nxt   = 4'd0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (accept) begin
            state_nxt = HELD;
            code_nxt  = scan_code;
            down_nxt  = 1'b1;
            cnt_nxt   = 4'd0;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [8:0] REP_FIRST = 9'(2 * REPEAT_SCANS);
    localparam logic [8:0] REP_NEXT  = 9'(REPEAT_SCANS);

    logic [8:0] rep_cnt, rep_cnt_nxt, rep_inc;
    logic       rep_first, rep_first_nxt, rep_fire;

    assign rep_inc = rep_cnt + 9'd1;

    // First repeat waits twice as long; a return from RELEASE_CHK resumes at the short period.
    always_comb begin
        rep_cnt_nxt   = rep_cnt;
        rep_first_nxt = rep_first;
        rep_fire      = 1'b0;
        if (accept) begin
            rep_cnt_nxt   = 9'd0;
            rep_first_nxt = 1'b1;
        end else if (eval_en && state == HELD && state_nxt == HELD) begin
            if (rep_inc == (rep_first ? REP_FIRST : REP_NEXT)) begin
                rep_fire      = 1'b1;
                rep_cnt_nxt   = 9'd0;
                rep_first_nxt = 1'b0;
            end else begin
                rep_cnt_nxt = rep_inc;
            end
        end else if (eval_en && state == RELEASE_CHK && state_nxt == HELD) begin
            rep_cnt_nxt   = 9'd0;
            rep_first_nxt = 1'b0;
        end else if (eval_en && state == HELD) begin
            rep_cnt_nxt = 9'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt   <= 9'd0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_first <= rep_first_nxt;
        end
    end

    assign valid_nxt = accept | rep_fire;
`else
    assign valid_nxt = accept;
`endif

    // Debounce state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'd0;
            db_cnt    <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            db_cnt    <= cnt_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_down  <= down_nxt;
        end
    end

endmodule
